// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  // Sequencer state: RUN is the normal issue state, MUL_WAIT counts down a multiply.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  // Default geometry of the 8-bit pipeline.
  localparam int DEF_AW      = 3;
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_CW      = 16;

  // A flushed pipeline register loads all zeros, which decodes as a NOP/bubble.
  localparam logic [7:0] NOP_INSN = 8'h00;

  // True when a decode source operand is read and names the given register.
  function automatic logic src_hit(input logic used, input logic [7:0] src,
                                   input logic [7:0] dst);
    src_hit = used & (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous reset and clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer: drives PC/fetch/decode enables and flushes for
// load-use hazards, taken branches and multi-cycle multiplies.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_stats,
  input  logic          dec_valid,
  input  logic          dec_use_a,
  input  logic          dec_use_b,
  input  logic [AW-1:0] dec_src_a,
  input  logic [AW-1:0] dec_src_b,
  input  logic          ex_valid,
  input  logic          ex_wr,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_dst,
  input  logic          ex_branch_taken,
  input  logic          ex_mul_start,
  output logic          pc_en,
  output logic          fetch_en,
  output logic          decode_en,
  output logic          fetch_flush,
  output logic          decode_flush,
  output logic          ex_hold,
  output logic          mul_done,
  output logic          busy,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  state_t     state_r, state_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic       hazard_s;
  logic       flush_inc_s;
  logic       stall_inc_s;

  // Load-use hazard: execute holds a load whose destination decode wants to read.
  always_comb begin
    hazard_s = ex_valid & ex_is_load & ex_wr & dec_valid &
               (src_hit(dec_use_a, 8'(dec_src_a), 8'(ex_dst)) |
                src_hit(dec_use_b, 8'(dec_src_b), 8'(ex_dst)));
  end

  // State and multiply down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and pipeline control decode; reset forces every output low.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    pc_en        = 1'b0;
    fetch_en     = 1'b0;
    decode_en    = 1'b0;
    fetch_flush  = 1'b0;
    decode_flush = 1'b0;
    ex_hold      = 1'b0;
    mul_done     = 1'b0;
    busy         = 1'b0;
    flush_inc_s  = 1'b0;
    if (rst) begin
      state_nxt_s = RUN;
      cnt_nxt_s   = 4'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_valid && ex_branch_taken) begin
            // Taken branch squashes fetch and decode; a multiply here is wrong-path.
            pc_en        = 1'b1;
            fetch_en     = 1'b1;
            decode_en    = 1'b1;
            fetch_flush  = 1'b1;
            decode_flush = 1'b1;
            flush_inc_s  = 1'b1;
          end else if (ex_valid && ex_mul_start) begin
            ex_hold     = 1'b1;
            state_nxt_s = MUL_WAIT;
            cnt_nxt_s   = 4'(MUL_LAT - 1);
          end else if (hazard_s) begin
            // Hold fetch/PC one cycle and push a bubble into execute.
            decode_en    = 1'b1;
            decode_flush = 1'b1;
          end else begin
            pc_en     = 1'b1;
            fetch_en  = 1'b1;
            decode_en = 1'b1;
          end
        end
        MUL_WAIT: begin
          busy = 1'b1;
          if (cnt_r != 4'd0) begin
            ex_hold   = 1'b1;
            cnt_nxt_s = cnt_r - 4'd1;
          end else begin
            mul_done    = 1'b1;
            pc_en       = 1'b1;
            fetch_en    = 1'b1;
            decode_en   = 1'b1;
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end
  end

  // Every non-reset cycle without a PC update counts as a stall.
  always_comb begin
    stall_inc_s = ~pc_en & ~rst;
  end

  sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_stats),
    .inc   (stall_inc_s),
    .count (stall_count)
  );

  sat_counter #(.W(CW)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_stats),
    .inc   (flush_inc_s),
    .count (flush_count)
  );

endmodule
